d_grf: RTL



---
 rtl/mips_pkg.sv | 8 +
 rtl/grf_read_bypass.sv | 34 +++
 rtl/d_grf.sv | 88 ++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file constants for the P6 pipeline
// Purpose: common widths and the hardwired-zero register index.
// Ports: none (package).
package mips_pkg;
  localparam int REG_W = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;
endpackage

// File: rtl/grf_read_bypass.sv
// rtl/grf_read_bypass.sv - combinational GRF read mux with zero and write-through rules
// Purpose: selects the data returned on one D-stage read port.
// Ports:
//   i_rd_addr  read address
//   i_wr_en    W-stage write enable
//   i_wr_addr  W-stage destination
//   i_wr_data  W-stage write data
//   i_stored   value currently held in storage at i_rd_addr
//   o_rd_data  read result
module grf_read_bypass
  import mips_pkg::*;
#(
  parameter int WIDTH = REG_W,
  parameter int AW    = REG_AW
) (
  input  logic [AW-1:0]    i_rd_addr,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [WIDTH-1:0] i_stored,
  output logic [WIDTH-1:0] o_rd_data
);

  // Zero wins over the bypass so a write aimed at $0 never leaks through.
  always_comb begin
    o_rd_data = i_stored;
    if (i_rd_addr == '0) begin
      o_rd_data = '0;
    end else if (i_wr_en && (i_wr_addr == i_rd_addr)) begin
      o_rd_data = i_wr_data;
    end
  end

endmodule

// File: rtl/d_grf.sv
// rtl/d_grf.sv - decode-stage general register file with write-trace port
// Purpose: 32x32 register file, one write-back per cycle, two bypassed reads.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   W_we/W_A3/W_Wdata     write-back enable, destination, data
//   W_pc                  PC of the instruction in W (trace only)
//   D_A1/D_A2             read addresses
//   D_RD1/D_RD2           combinational read data
//   trace_*               registered record of last cycle's write-back
module d_grf
  import mips_pkg::*;
#(
  parameter int WIDTH = REG_W,
  parameter int NREG  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    W_we,
  input  logic [$clog2(NREG)-1:0] W_A3,
  input  logic [WIDTH-1:0]        W_Wdata,
  input  logic [31:0]             W_pc,
  input  logic [$clog2(NREG)-1:0] D_A1,
  input  logic [$clog2(NREG)-1:0] D_A2,
  output logic [WIDTH-1:0]        D_RD1,
  output logic [WIDTH-1:0]        D_RD2,
  output logic                    trace_valid,
  output logic [31:0]             trace_pc,
  output logic [$clog2(NREG)-1:0] trace_reg,
  output logic [WIDTH-1:0]        trace_data
);

  localparam int AW = $clog2(NREG);

  logic [WIDTH-1:0] r_regs [NREG];
  logic [WIDTH-1:0] w_stored1;
  logic [WIDTH-1:0] w_stored2;

  // Entry 0 is cleared by reset and never written, but the read mux
  // forces zero anyway so its contents do not matter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (W_we && (W_A3 != '0)) begin
      r_regs[W_A3] <= W_Wdata;
    end
  end

  // Writes to $0 are still traced; only storage ignores them.
  always_ff @(posedge clk) begin
    if (reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_reg   <= '0;
      trace_data  <= '0;
    end else begin
      trace_valid <= W_we;
      if (W_we) begin
        trace_pc   <= W_pc;
        trace_reg  <= W_A3;
        trace_data <= W_Wdata;
      end
    end
  end

  assign w_stored1 = r_regs[D_A1];
  assign w_stored2 = r_regs[D_A2];

  grf_read_bypass #(.WIDTH(WIDTH), .AW(AW)) u_rd1 (
    .i_rd_addr (D_A1),
    .i_wr_en   (W_we),
    .i_wr_addr (W_A3),
    .i_wr_data (W_Wdata),
    .i_stored  (w_stored1),
    .o_rd_data (D_RD1)
  );

  grf_read_bypass #(.WIDTH(WIDTH), .AW(AW)) u_rd2 (
    .i_rd_addr (D_A2),
    .i_wr_en   (W_we),
    .i_wr_addr (W_A3),
    .i_wr_data (W_Wdata),
    .i_stored  (w_stored2),
    .o_rd_data (D_RD2)
  );

endmodule
